// File: rtl/vec_dot_engine.sv
// Streaming dot-product engine: loads vectors A and B element by element, runs N MAC cycles, then holds the result until it is consumed.
// Optional build macro VEC_DOT_SAT_EN selects a saturated out_data; by default out_data is truncated.
module vec_dot_engine #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 8,
  parameter int unsigned OUT_W = 8,
  localparam int unsigned ACC_W = 2 * W + $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf,
  output logic [ACC_W-1:0] acc_full,
  output logic [1:0]       state
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_LOAD_A = 2'd0;
  localparam logic [1:0] S_LOAD_B = 2'd1;
  localparam logic [1:0] S_MAC    = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  logic [1:0]       state_next;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_next;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] prod;
  logic             idx_last;
  logic             a_we;
  logic             b_we;

  logic [W-1:0] a_mem [N];
  logic [W-1:0] b_mem [N];

  assign idx_last = (idx_q == IDX_W'(N - 1));
  assign prod     = ACC_W'(a_mem[idx_q]) * ACC_W'(b_mem[idx_q]);

  // State, index and accumulator registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_LOAD_A;
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      state <= state_next;
      idx_q <= idx_next;
      acc_q <= acc_next;
    end
  end

  // Operand storage; contents survive reset since a new load overwrites every entry
  always_ff @(posedge clk) begin
    if (a_we) a_mem[idx_q] <= in_data;
    if (b_we) b_mem[idx_q] <= in_data;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    acc_next   = acc_q;
    a_we       = 1'b0;
    b_we       = 1'b0;
    case (state)
      S_LOAD_A: begin
        if (in_valid) begin
          a_we = 1'b1;
          if (idx_last) begin
            state_next = S_LOAD_B;
            idx_next   = '0;
          end else begin
            idx_next = idx_q + IDX_W'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (in_valid) begin
          b_we = 1'b1;
          if (idx_last) begin
            state_next = S_MAC;
            idx_next   = '0;
            acc_next   = '0;
          end else begin
            idx_next = idx_q + IDX_W'(1);
          end
        end
      end
      S_MAC: begin
        acc_next = acc_q + prod;
        if (idx_last) begin
          state_next = S_OUT;
          idx_next   = '0;
        end else begin
          idx_next = idx_q + IDX_W'(1);
        end
      end
      default: begin
        if (out_ready) state_next = S_LOAD_A;
      end
    endcase
  end

  // Outputs are pure decodes of the state and accumulator registers
  assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign out_valid = (state == S_OUT);
  assign acc_full  = acc_q;
  assign out_ovf   = |(acc_q >> OUT_W);

`ifdef VEC_DOT_SAT_EN
  assign out_data = out_ovf ? {OUT_W{1'b1}} : OUT_W'(acc_q);
`else
  assign out_data = OUT_W'(acc_q);
`endif

endmodule

// File: tb/tb_vec_dot_engine.sv
// Self-checking bench for vec_dot_engine: table of vectors (directed + random) against a plain dot-product model,
// plus hand-written reset, hold and N=1 sequences.
module tb_vec_dot_engine;

  localparam int unsigned W = 8;
  localparam int unsigned N = 8;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned ACC_W = 2 * W + $clog2(N + 1);
  localparam int unsigned ACC1_W = 2 * W + $clog2(2);

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_ovf;
  logic [ACC_W-1:0] acc_full;
  logic [1:0]       state;

  logic [W-1:0]      n1_in_data;
  logic              n1_in_valid;
  logic              n1_in_ready;
  logic [OUT_W-1:0]  n1_out_data;
  logic              n1_out_valid;
  logic              n1_out_ready;
  logic              n1_out_ovf;
  logic [ACC1_W-1:0] n1_acc_full;
  logic [1:0]        n1_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_dot_engine #(.W(W), .N(N), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ovf(out_ovf),
    .acc_full(acc_full), .state(state)
  );

  vec_dot_engine #(.W(W), .N(1), .OUT_W(OUT_W)) dut1 (
    .clk(clk), .rst(rst), .in_data(n1_in_data), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .out_data(n1_out_data), .out_valid(n1_out_valid), .out_ready(n1_out_ready), .out_ovf(n1_out_ovf),
    .acc_full(n1_acc_full), .state(n1_state)
  );

  typedef struct {
    logic [N-1:0][W-1:0] a;
    logic [N-1:0][W-1:0] b;
    int unsigned         gap;
    int unsigned         hold;
    int unsigned         exp_acc;
    logic                exp_ovf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: plain unsigned dot product
  function automatic int unsigned dot(input logic [N-1:0][W-1:0] a, input logic [N-1:0][W-1:0] b);
    int unsigned s = 0;
    for (int k = 0; k < int'(N); k++) s += int'(a[k]) * int'(b[k]);
    return s;
  endfunction

  function automatic int unsigned exp_data(input int unsigned acc);
    int unsigned mx = (1 << OUT_W) - 1;
`ifdef VEC_DOT_SAT_EN
    return (acc > mx) ? mx : acc;
`else
    return acc & mx;
`endif
  endfunction

  // Called at a negedge; one element accepted on the next posedge
  task automatic beat(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [N-1:0][W-1:0] a, input logic [N-1:0][W-1:0] b, input int unsigned gap);
    for (int k = 0; k < int'(2 * N); k++) begin
      beat((k < int'(N)) ? a[k] : b[k - int'(N)]);
      if (k != int'(2 * N) - 1)
        repeat (gap) @(negedge clk);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int unsigned cnt;
    logic [OUT_W-1:0] d0;
    chk({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    load(v.a, v.b, v.gap);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(negedge clk);
      cnt++;
    end
    chk({name, "_latency"}, cnt, N);
    chk({name, "_out_data"}, 32'(out_data), exp_data(v.exp_acc));
    chk({name, "_out_ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
    chk({name, "_acc_full"}, 32'(acc_full), v.exp_acc);
    d0 = out_data;
    for (int h = 0; h < int'(v.hold); h++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_hold_data"}, 32'(out_data), 32'(d0));
      chk({name, "_hold_state"}, 32'(state), 32'd3);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({name, "_ret_state"}, 32'(state), 32'd0);
    chk({name, "_ret_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_ret_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0][W-1:0] ra;
    logic [N-1:0][W-1:0] rb;
    int unsigned cnt;

    rst = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    n1_in_data = '0; n1_in_valid = 1'b0; n1_out_ready = 1'b0;

    for (int k = 0; k < int'(N); k++) begin
      tbl[0].a[k] = W'(k + 1);  tbl[0].b[k] = W'(k + 2);
      tbl[1].a[k] = '1;         tbl[1].b[k] = '1;
      tbl[2].a[k] = '0;         tbl[2].b[k] = '1;
    end
    tbl[0].gap = 1; tbl[0].hold = 5; tbl[0].exp_acc = 240;    tbl[0].exp_ovf = 1'b0;
    tbl[1].gap = 0; tbl[1].hold = 1; tbl[1].exp_acc = 520200; tbl[1].exp_ovf = 1'b1;
    tbl[2].gap = 2; tbl[2].hold = 0; tbl[2].exp_acc = 0;      tbl[2].exp_ovf = 1'b0;
    for (int t = 3; t < 8; t++) begin
      for (int k = 0; k < int'(N); k++) begin
        tbl[t].a[k] = W'($urandom_range(0, (t == 3) ? 3 : 255));
        tbl[t].b[k] = W'($urandom_range(0, (t == 3) ? 3 : 255));
      end
      tbl[t].gap     = $urandom_range(0, 2);
      tbl[t].hold    = $urandom_range(0, 3);
      tbl[t].exp_acc = dot(tbl[t].a, tbl[t].b);
      tbl[t].exp_ovf = (tbl[t].exp_acc > (1 << OUT_W) - 1);
    end

    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_acc_full", 32'(acc_full), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int t = 0; t < 8; t++) run_vec($sformatf("vec%0d", t), tbl[t]);

    // Reset after 3 A beats, coinciding with a further beat: reset wins, partial load discarded
    for (int k = 0; k < 3; k++) beat(W'(200 + k));
    in_valid = 1'b1; in_data = 8'd99;
    pulse_reset();
    in_valid = 1'b0;
    chk("midload_rst_state", 32'(state), 32'd0);
    chk("midload_rst_in_ready", 32'(in_ready), 32'd1);
    run_vec("after_midload_rst", tbl[0]);

    // Reset during MAC: result must never appear
    load(tbl[1].a, tbl[1].b, 0);
    repeat (3) @(negedge clk);
    chk("mac_state", 32'(state), 32'd2);
    pulse_reset();
    cnt = 0;
    for (int c = 0; c < 2 * int'(N); c++) begin
      if (out_valid) cnt++;
      @(negedge clk);
    end
    chk("macrst_no_valid", cnt, 0);
    chk("macrst_state", 32'(state), 32'd0);
    chk("macrst_acc_full", 32'(acc_full), 32'd0);
    run_vec("after_mac_rst", tbl[0]);

    // N=1 instance: A=7, B=9, result one cycle after the B beat
    n1_in_valid = 1'b1; n1_in_data = 8'd7;
    @(negedge clk);
    n1_in_data = 8'd9;
    @(negedge clk);
    n1_in_valid = 1'b0;
    chk("n1_state_mac", 32'(n1_state), 32'd2);
    chk("n1_valid_early", 32'(n1_out_valid), 32'd0);
    @(negedge clk);
    chk("n1_out_valid", 32'(n1_out_valid), 32'd1);
    chk("n1_out_data", 32'(n1_out_data), 32'd63);
    chk("n1_acc_full", 32'(n1_acc_full), 32'd63);
    n1_out_ready = 1'b1;
    @(negedge clk);
    n1_out_ready = 1'b0;
    chk("n1_ret_state", 32'(n1_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
